// File: rtl/tcp_ctrl_pkg.sv
// Shared types and constants for the single-connection TCP receive controller.
package tcp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED      = 3'd0,
        ST_LISTEN      = 3'd1,
        ST_SYN_RCVD    = 3'd2,
        ST_ESTABLISHED = 3'd3,
        ST_LAST_ACK    = 3'd4
    } conn_state_e;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_ACK = 4;

    localparam logic [7:0] REQ_ACK     = 8'h10;
    localparam logic [7:0] REQ_FIN_ACK = 8'h11;
    localparam logic [7:0] REQ_SYN_ACK = 8'h12;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/tcp_rx_conn_ctrl_seg_check.sv
// Combinational segment qualification: port/checksum validity and in-order test.
module tcp_seg_check
    import tcp_ctrl_pkg::*;
(
    input  conn_state_e  state,
    input  logic [15:0]  local_port,
    input  logic [15:0]  peer_port,
    input  logic [31:0]  rcv_nxt,
    input  logic [15:0]  src_port,
    input  logic [15:0]  dst_port,
    input  logic [31:0]  seq_num,
    input  logic         checksum_ok,
    output logic         valid,
    output logic         in_order
);

    // Before a peer is bound (LISTEN) any source port is acceptable
    assign valid = checksum_ok
                && (dst_port == local_port)
                && (state != ST_CLOSED)
                && ((state == ST_LISTEN) || (src_port == peer_port));

    assign in_order = (seq_num == rcv_nxt);

endmodule

// File: rtl/tcp_rx_conn_ctrl.sv
// Passive-open TCP receive connection controller: per-segment commit/drop,
// sequence tracking and SYN-ACK / ACK / FIN-ACK request generation.
module tcp_rx_conn_ctrl
    import tcp_ctrl_pkg::*;
#(
    parameter logic [31:0] ISS         = 32'h0000_1000,
    parameter logic [15:0] RX_WINDOW   = 16'd4096,
    parameter int unsigned SYN_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_enable,
    input  logic [15:0] cfg_local_port,
    input  logic        meta_valid,
    output logic        meta_ready,
    input  logic [15:0] meta_src_port,
    input  logic [15:0] meta_dst_port,
    input  logic [31:0] meta_seq_num,
    input  logic [31:0] meta_ack_num,
    input  logic [7:0]  meta_flags,
    input  logic [15:0] meta_window_size,
    input  logic [15:0] meta_payload_len,
    input  logic        meta_checksum_ok,
    output logic        pl_commit,
    output logic        pl_drop,
    output logic        ack_req_valid,
    input  logic        ack_req_ready,
    output logic [7:0]  ack_req_flags,
    output logic [31:0] ack_req_seq,
    output logic [31:0] ack_req_ack,
    output logic [15:0] ack_req_dst_port,
    output logic [15:0] ack_req_window,
    output logic [2:0]  conn_state,
    output logic [31:0] rcv_nxt,
    output logic [31:0] snd_nxt,
    output logic [15:0] peer_port,
    output logic [15:0] peer_window,
    output logic [15:0] drop_count
);

    localparam int TIMER_W = $clog2(SYN_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SYN_TIMEOUT - 1);

    conn_state_e        state_r, state_next_s;
    logic [31:0]        rcv_nxt_r, rcv_nxt_next_s, snd_nxt_r, snd_nxt_next_s, rcv_sum_s;
    logic [15:0]        peer_port_r, peer_port_next_s, peer_window_r, peer_window_next_s, drop_count_r;
    logic               pl_commit_r, pl_drop_r, commit_s, drop_s, count_drop_s;
    logic               req_gen_s;
    logic [7:0]         req_flags_s;
    logic [31:0]        req_seq_s, req_ack_s;
    logic               ack_req_valid_r;
    logic [7:0]         ack_req_flags_r;
    logic [31:0]        ack_req_seq_r, ack_req_ack_r;
    logic [15:0]        ack_req_dst_r;
    logic [TIMER_W-1:0] timer_r;
    logic               hs_s, seg_valid_s, seg_in_order_s, seg_ok_s, rst_ok_s;
    logic               f_fin, f_syn, f_rst, f_ack, ack_match_s, est_fin_s, est_path_s, timeout_s;
    logic               unused_flags_s;

    tcp_seg_check u_seg_check (
        .state       (state_r),
        .local_port  (cfg_local_port),
        .peer_port   (peer_port_r),
        .rcv_nxt     (rcv_nxt_r),
        .src_port    (meta_src_port),
        .dst_port    (meta_dst_port),
        .seq_num     (meta_seq_num),
        .checksum_ok (meta_checksum_ok),
        .valid       (seg_valid_s),
        .in_order    (seg_in_order_s)
    );

    assign f_fin          = meta_flags[FLAG_FIN];
    assign f_syn          = meta_flags[FLAG_SYN];
    assign f_rst          = meta_flags[FLAG_RST];
    assign f_ack          = meta_flags[FLAG_ACK];
    assign unused_flags_s = ^{meta_flags[7:5], meta_flags[3]};

    assign meta_ready  = !ack_req_valid_r;
    assign hs_s        = meta_valid && meta_ready;
    assign seg_ok_s    = seg_valid_s && cfg_enable;
    assign ack_match_s = f_ack && (meta_ack_num == snd_nxt_r);
    assign est_fin_s   = seg_in_order_s && f_fin;
    assign rcv_sum_s   = rcv_nxt_r + {16'd0, meta_payload_len};
    assign rst_ok_s    = f_rst && seg_in_order_s
                      && (state_r inside {ST_SYN_RCVD, ST_ESTABLISHED, ST_LAST_ACK});
    // Any accepted segment takes precedence over the SYN_RCVD timeout
    assign timeout_s   = (state_r == ST_SYN_RCVD) && (timer_r == TIMER_LAST) && !hs_s;

    // Connection state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_CLOSED;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state selection
    always_comb begin
        state_next_s = state_r;
        if (!cfg_enable) begin
            state_next_s = ST_CLOSED;
        end else if (hs_s && seg_ok_s) begin
            if (rst_ok_s) begin
                state_next_s = ST_LISTEN;
            end else if (f_rst) begin
                state_next_s = state_r;
            end else begin
                case (state_r)
                    ST_LISTEN: begin
                        if (f_syn && !f_ack) begin
                            state_next_s = ST_SYN_RCVD;
                        end else begin
                            state_next_s = state_r;
                        end
                    end
                    ST_SYN_RCVD: begin
                        if (ack_match_s) begin
                            state_next_s = est_fin_s ? ST_LAST_ACK : ST_ESTABLISHED;
                        end else begin
                            state_next_s = state_r;
                        end
                    end
                    ST_ESTABLISHED: begin
                        if (est_fin_s) begin
                            state_next_s = ST_LAST_ACK;
                        end else begin
                            state_next_s = state_r;
                        end
                    end
                    ST_LAST_ACK: begin
                        if (ack_match_s) begin
                            state_next_s = ST_LISTEN;
                        end else begin
                            state_next_s = state_r;
                        end
                    end
                    default: state_next_s = state_r;
                endcase
            end
        end else if (state_r == ST_CLOSED) begin
            state_next_s = ST_LISTEN;
        end else if (timeout_s) begin
            state_next_s = ST_LISTEN;
        end else begin
            state_next_s = state_r;
        end
    end

    // Per-segment decision, sequencing updates and request contents
    always_comb begin
        rcv_nxt_next_s     = rcv_nxt_r;
        snd_nxt_next_s     = snd_nxt_r;
        peer_port_next_s   = peer_port_r;
        peer_window_next_s = peer_window_r;
        commit_s           = 1'b0;
        drop_s             = 1'b0;
        count_drop_s       = 1'b0;
        req_gen_s          = 1'b0;
        req_flags_s        = REQ_ACK;
        req_seq_s          = snd_nxt_r;
        req_ack_s          = rcv_nxt_r;
        est_path_s         = 1'b0;
        if (hs_s) begin
            if (!seg_ok_s || (f_rst && !rst_ok_s)) begin
                drop_s       = 1'b1;
                count_drop_s = 1'b1;
            end else if (rst_ok_s) begin
                drop_s           = 1'b1;
                peer_port_next_s = 16'd0;
            end else begin
                case (state_r)
                    ST_LISTEN: begin
                        if (f_syn && !f_ack) begin
                            commit_s         = 1'b1;
                            peer_port_next_s = meta_src_port;
                            rcv_nxt_next_s   = meta_seq_num + 32'd1;
                            snd_nxt_next_s   = ISS + 32'd1;
                            req_gen_s        = 1'b1;
                            req_flags_s      = REQ_SYN_ACK;
                            req_seq_s        = ISS;
                            req_ack_s        = meta_seq_num + 32'd1;
                        end else begin
                            drop_s       = 1'b1;
                            count_drop_s = 1'b1;
                        end
                    end
                    ST_SYN_RCVD: begin
                        if (ack_match_s) begin
                            est_path_s = 1'b1;
                        end else begin
                            drop_s       = 1'b1;
                            count_drop_s = 1'b1;
                        end
                    end
                    ST_ESTABLISHED: est_path_s = 1'b1;
                    ST_LAST_ACK: begin
                        if (ack_match_s) begin
                            commit_s         = 1'b1;
                            peer_port_next_s = 16'd0;
                        end else begin
                            drop_s       = 1'b1;
                            count_drop_s = 1'b1;
                        end
                    end
                    default: begin
                        drop_s       = 1'b1;
                        count_drop_s = 1'b1;
                    end
                endcase

                // ESTABLISHED rules, also reached by the ACK that completes the handshake
                if (est_path_s) begin
                    peer_window_next_s = meta_window_size;
                    if (seg_in_order_s) begin
                        commit_s = 1'b1;
                        if (f_fin) begin
                            rcv_nxt_next_s = rcv_sum_s + 32'd1;
                            snd_nxt_next_s = snd_nxt_r + 32'd1;
                            req_gen_s      = 1'b1;
                            req_flags_s    = REQ_FIN_ACK;
                            req_ack_s      = rcv_sum_s + 32'd1;
                        end else begin
                            rcv_nxt_next_s = rcv_sum_s;
                            req_gen_s      = (meta_payload_len != 16'd0);
                            req_ack_s      = rcv_sum_s;
                        end
                    end else begin
                        drop_s       = 1'b1;
                        count_drop_s = 1'b1;
                        req_gen_s    = 1'b1;
                    end
                end else begin
                    peer_window_next_s = peer_window_r;
                end
            end
        end else begin
            commit_s = 1'b0;
        end
    end

    // Sequencing context, decision pulses and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcv_nxt_r     <= 32'd0;
            snd_nxt_r     <= 32'd0;
            peer_port_r   <= 16'd0;
            peer_window_r <= 16'd0;
            pl_commit_r   <= 1'b0;
            pl_drop_r     <= 1'b0;
            drop_count_r  <= 16'd0;
        end else begin
            rcv_nxt_r     <= rcv_nxt_next_s;
            snd_nxt_r     <= snd_nxt_next_s;
            peer_port_r   <= peer_port_next_s;
            peer_window_r <= peer_window_next_s;
            pl_commit_r   <= commit_s;
            pl_drop_r     <= drop_s;
            if (count_drop_s) begin
                drop_count_r <= sat_inc16(drop_count_r);
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    // SYN_RCVD dwell timer, cleared on entry and on exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= '0;
        end else if ((state_r != ST_SYN_RCVD) || (state_next_s != ST_SYN_RCVD)) begin
            timer_r <= '0;
        end else if (timer_r != TIMER_LAST) begin
            timer_r <= timer_r + TIMER_W'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // Outgoing request register, held until the TX path accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_req_valid_r <= 1'b0;
            ack_req_flags_r <= 8'd0;
            ack_req_seq_r   <= 32'd0;
            ack_req_ack_r   <= 32'd0;
            ack_req_dst_r   <= 16'd0;
        end else if (hs_s && req_gen_s) begin
            ack_req_valid_r <= 1'b1;
            ack_req_flags_r <= req_flags_s;
            ack_req_seq_r   <= req_seq_s;
            ack_req_ack_r   <= req_ack_s;
            ack_req_dst_r   <= meta_src_port;
        end else if (ack_req_valid_r && ack_req_ready) begin
            ack_req_valid_r <= 1'b0;
        end else begin
            ack_req_valid_r <= ack_req_valid_r;
        end
    end

    assign pl_commit        = pl_commit_r;
    assign pl_drop          = pl_drop_r;
    assign ack_req_valid    = ack_req_valid_r;
    assign ack_req_flags    = ack_req_flags_r;
    assign ack_req_seq      = ack_req_seq_r;
    assign ack_req_ack      = ack_req_ack_r;
    assign ack_req_dst_port = ack_req_dst_r;
    assign ack_req_window   = ack_req_valid_r ? RX_WINDOW : 16'd0;
    assign conn_state       = state_r;
    assign rcv_nxt          = rcv_nxt_r;
    assign snd_nxt          = snd_nxt_r;
    assign peer_port        = peer_port_r;
    assign peer_window      = peer_window_r;
    assign drop_count       = drop_count_r;

endmodule
